// File: rtl/data_ram_arbiter_pkg.sv
// rtl/data_ram_arbiter_pkg.sv - shared types and defaults for the data_ram arbiter
package data_ram_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_SEL_W  = ARB_DATA_W / 8;

  // Transaction sequencer states: one request is latched in IDLE, driven to the
  // RAM for exactly one cycle in ACCESS, and acknowledged in RESP.
  typedef enum logic [1:0] {
    ArbIdle   = 2'b00,
    ArbAccess = 2'b01,
    ArbResp   = 2'b10
  } arb_state_e;

  // Master identifiers, also used as the last-grant memory for round-robin.
  typedef enum logic {
    ArbM0 = 1'b0,
    ArbM1 = 1'b1
  } arb_grant_e;

  // The master that did not receive grant g.
  function automatic arb_grant_e arb_other(input arb_grant_e g);
    return (g == ArbM0) ? ArbM1 : ArbM0;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// rtl/data_ram_arbiter_if.sv - bundle of both master ports and the data_ram port
interface data_ram_arbiter_if
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int SEL_W  = ARB_SEL_W
);

  // m0: openmips data-memory port
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [SEL_W-1:0]  m0_sel;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_stall;

  // m1: DMA / debug loader
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [SEL_W-1:0]  m1_sel;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  // data_ram port
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [SEL_W-1:0]  ram_sel;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side: receives both master requests and owns the RAM port.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    output m0_ack, m0_rdata, m0_stall,
    input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
    output m1_ack, m1_rdata,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );

  // Environment side: the two masters plus the RAM itself.
  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    input  m0_ack, m0_rdata, m0_stall,
    output m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
    input  m1_ack, m1_rdata,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/data_ram_arbiter_rr_pick2.sv
// rtl/data_ram_arbiter_rr_pick2.sv - combinational two-way grant picker
module arb_rr_pick2
  import data_ram_arbiter_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  arb_grant_e last_i,
  input  logic       mode_i,   // 0 = round-robin, 1 = m0 always wins ties
  output arb_grant_e grant_o
);

  // A lone requester always wins; a tie goes to m0 in fixed mode, otherwise to
  // whichever master was not served last. With no request the output is a
  // don't-care and defaults to m0.
  always_comb begin
    grant_o = ArbM0;
    if (req0_i && req1_i) begin
      grant_o = mode_i ? ArbM0 : arb_other(last_i);
    end else if (req1_i) begin
      grant_o = ArbM1;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - shares the single data_ram port between openmips and a secondary master
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int SEL_W     = ARB_SEL_W,
  parameter int PRIO_MODE = 0
) (
  input logic                clk_i,
  input logic                rst_ni,
  data_ram_arbiter_if.slave  bus_io
);

  arb_state_e        state_q,     state_d;
  arb_grant_e        last_q,      last_d;
  arb_grant_e        gnt_q,       gnt_d;
  logic              ram_ce_q,    ram_ce_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [SEL_W-1:0]  ram_sel_q,   ram_sel_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;

  arb_grant_e pick_gnt;
  logic       m0_ack;
  logic       m1_ack;

  arb_rr_pick2 u_pick (
    .req0_i  (bus_io.m0_req),
    .req1_i  (bus_io.m1_req),
    .last_i  (last_q),
    .mode_i  (PRIO_MODE != 0),
    .grant_o (pick_gnt)
  );

  // Next-state logic: latch the winner in IDLE, run one RAM cycle, then respond.
  // The RAM-side signals are computed here so they leave the block registered
  // and never follow the live master inputs.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    ram_ce_d    = ram_ce_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      ArbIdle: begin
        if (bus_io.m0_req || bus_io.m1_req) begin
          state_d  = ArbAccess;
          gnt_d    = pick_gnt;
          last_d   = pick_gnt;
          ram_ce_d = 1'b1;
          if (pick_gnt == ArbM1) begin
            ram_we_d    = bus_io.m1_we;
            ram_addr_d  = bus_io.m1_addr;
            ram_sel_d   = bus_io.m1_sel;
            ram_wdata_d = bus_io.m1_wdata;
          end else begin
            ram_we_d    = bus_io.m0_we;
            ram_addr_d  = bus_io.m0_addr;
            ram_sel_d   = bus_io.m0_sel;
            ram_wdata_d = bus_io.m0_wdata;
          end
        end
      end

      ArbAccess: begin
        // The RAM sees this cycle's closing edge as the commit point; reads are
        // captured at the same edge, writes return zero.
        state_d  = ArbResp;
        ram_ce_d = 1'b0;
        ram_we_d = 1'b0;
        rdata_d  = ram_we_q ? '0 : bus_io.ram_rdata;
      end

      ArbResp: begin
        state_d = ArbIdle;
        rdata_d = '0;
      end

      default: begin
        state_d  = ArbIdle;
        ram_ce_d = 1'b0;
        ram_we_d = 1'b0;
        rdata_d  = '0;
      end
    endcase
  end

  // State register; reset abandons any in-flight access and gives m0 the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ArbIdle;
      last_q      <= ArbM1;
      gnt_q       <= ArbM0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Only the granted master sees ack and data, and only during RESP.
  always_comb begin
    m0_ack = (state_q == ArbResp) && (gnt_q == ArbM0);
    m1_ack = (state_q == ArbResp) && (gnt_q == ArbM1);
  end

  assign bus_io.m0_ack    = m0_ack;
  assign bus_io.m1_ack    = m1_ack;
  assign bus_io.m0_rdata  = m0_ack ? rdata_q : '0;
  assign bus_io.m1_rdata  = m1_ack ? rdata_q : '0;
  assign bus_io.m0_stall  = bus_io.m0_req & ~m0_ack;

  assign bus_io.ram_ce    = ram_ce_q;
  assign bus_io.ram_we    = ram_we_q;
  assign bus_io.ram_addr  = ram_addr_q;
  assign bus_io.ram_sel   = ram_sel_q;
  assign bus_io.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter
module tb_data_ram_arbiter;
  import data_ram_arbiter_pkg::*;

  typedef struct {
    logic        active;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } mreq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_ram_arbiter_if bus ();
  data_ram_arbiter_if bus_fp ();

  data_ram_arbiter #(.PRIO_MODE(0)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  data_ram_arbiter #(.PRIO_MODE(1)) dut_fp (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus_fp)
  );

  // Behavioural data_ram behind the round-robin instance.
  logic [31:0] ram_mem [64] = '{default: 32'h0};
  always_comb bus.ram_rdata = bus.ram_ce ? ram_mem[bus.ram_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (bus.ram_ce && bus.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_sel[b]) ram_mem[bus.ram_addr[7:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end
  assign bus_fp.ram_rdata = 32'h0;

  // Reference model: memory contents plus one outstanding transaction.
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  mreq_t       mst [2];
  mreq_t       lat;
  bit          pv;
  int          own;
  int          last_own;
  int          ack_cyc;
  logic [31:0] exp_rd;
  bit          keep_req;
  int          cyc;
  int          stall_cnt;
  int          act_m [$];
  int          act_c [$];
  logic [31:0] act_d [$];
  int          errors;
  int          checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic new_req(input int m);
    mst[m].active = 1'b1;
    mst[m].we     = 1'($urandom_range(0, 1));
    mst[m].addr   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    mst[m].sel    = 4'($urandom_range(1, 15));
    mst[m].wdata  = $urandom;
  endtask

  task automatic set_req(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mst[m].active = 1'b1;
    mst[m].we     = we;
    mst[m].addr   = addr;
    mst[m].sel    = 4'hF;
    mst[m].wdata  = wdata;
  endtask

  // One clock cycle: drive masters, compare outputs to the model, advance the model.
  task automatic step(input logic rst_v);
    logic e_ack0, e_ack1, e_ce;
    int   idx;
    @(negedge clk);
    rst_n        = rst_v;
    bus.m0_req   = mst[0].active;
    bus.m0_we    = mst[0].we;
    bus.m0_addr  = mst[0].addr;
    bus.m0_sel   = mst[0].sel;
    bus.m0_wdata = mst[0].wdata;
    bus.m1_req   = mst[1].active;
    bus.m1_we    = mst[1].we;
    bus.m1_addr  = mst[1].addr;
    bus.m1_sel   = mst[1].sel;
    bus.m1_wdata = mst[1].wdata;
    #1;
    if (!rst_v) begin
      pv       = 1'b0;
      last_own = 1;
    end
    e_ack0 = pv && (cyc == ack_cyc) && (own == 0);
    e_ack1 = pv && (cyc == ack_cyc) && (own == 1);
    e_ce   = pv && (cyc == ack_cyc - 1);
    check("m0_ack", bus.m0_ack, e_ack0);
    check("m1_ack", bus.m1_ack, e_ack1);
    check("m0_rdata", bus.m0_rdata, e_ack0 ? exp_rd : 32'h0);
    check("m1_rdata", bus.m1_rdata, e_ack1 ? exp_rd : 32'h0);
    check("m0_stall", bus.m0_stall, mst[0].active & ~e_ack0);
    check("ram_ce", bus.ram_ce, e_ce);
    if (e_ce) begin
      check("ram_we", bus.ram_we, lat.we);
      check("ram_addr", bus.ram_addr, lat.addr);
      check("ram_sel", bus.ram_sel, lat.sel);
      check("ram_wdata", bus.ram_wdata, lat.wdata);
    end
    if (!rst_v) begin
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_ram_addr", bus.ram_addr, 0);
      check("rst_ram_sel", bus.ram_sel, 0);
      check("rst_ram_wdata", bus.ram_wdata, 0);
    end
    if (bus.m0_ack === 1'b1) begin act_m.push_back(0); act_c.push_back(cyc); act_d.push_back(bus.m0_rdata); end
    if (bus.m1_ack === 1'b1) begin act_m.push_back(1); act_c.push_back(cyc); act_d.push_back(bus.m1_rdata); end
    if (bus.m0_stall === 1'b1) stall_cnt++;

    if (rst_v) begin
      if (e_ce) begin
        idx = int'(lat.addr[7:2]);
        if (lat.we) begin
          for (int b = 0; b < 4; b++)
            if (lat.sel[b]) ref_mem[idx][8*b +: 8] = lat.wdata[8*b +: 8];
          exp_rd = 32'h0;
        end else begin
          exp_rd = ref_mem[idx];
        end
      end else if (pv && cyc == ack_cyc) begin
        pv = 1'b0;
        if (keep_req) new_req(own);
        else mst[own].active = 1'b0;
      end else if (!pv && (mst[0].active || mst[1].active)) begin
        if (mst[0].active && mst[1].active) own = 1 - last_own;
        else own = mst[1].active ? 1 : 0;
        last_own = own;
        lat      = mst[own];
        pv       = 1'b1;
        ack_cyc  = cyc + 2;
      end
    end
    cyc++;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target;
    target = act_m.size() + n;
    for (int i = 0; i < budget && act_m.size() < target; i++) step(1'b1);
    if (act_m.size() < target) check("ack_timeout", act_m.size(), target);
  endtask

  task automatic wait_access_of(input int m);
    int i;
    for (i = 0; i < 20 && !(pv && cyc == ack_cyc - 1 && own == m); i++) step(1'b1);
    if (i == 20) check("access_timeout", 0, 1);
  endtask

  task automatic drain();
    int i;
    keep_req = 1'b0;
    for (i = 0; i < 30 && (pv || mst[0].active || mst[1].active); i++) step(1'b1);
    if (i == 30) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int base;
    int n0;
    int fp0;
    int fp1;
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    pv       = 1'b0;
    last_own = 1;
    keep_req = 1'b0;
    exp_rd   = 32'h0;
    for (int m = 0; m < 2; m++) mst[m] = '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_sel = 4'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_sel = 4'h0; bus.m1_wdata = 32'h0;
    bus_fp.m0_req = 1'b0; bus_fp.m0_we = 1'b0; bus_fp.m0_addr = 32'h0; bus_fp.m0_sel = 4'h0; bus_fp.m0_wdata = 32'h0;
    bus_fp.m1_req = 1'b0; bus_fp.m1_we = 1'b0; bus_fp.m1_addr = 32'h0; bus_fp.m1_sel = 4'h0; bus_fp.m1_wdata = 32'h0;

    // Reset held with both masters requesting, then the first tie goes to m0.
    new_req(0);
    new_req(1);
    repeat (3) step(1'b0);
    act_m.delete(); act_c.delete(); act_d.delete();
    wait_acks(1, 10);
    check("first_grant", act_m[0], 0);
    drain();

    // m0 write then read back, both with two-cycle latency.
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    n0 = cyc;
    wait_acks(1, 10);
    check("wr_latency", act_c[act_c.size()-1], n0 + 2);
    step(1'b1);
    set_req(0, 1'b0, 32'h10, 32'h0);
    n0 = cyc;
    wait_acks(1, 10);
    check("rd_latency", act_c[act_c.size()-1], n0 + 2);
    check("rd_data", act_d[act_d.size()-1], 32'hDEADBEEF);
    drain();

    // Continuous contention: last winner was m0, so grants alternate from m1.
    keep_req = 1'b1;
    new_req(0);
    new_req(1);
    base = act_m.size();
    wait_acks(8, 40);
    for (int i = 0; i < 8; i++) begin
      check("rr_order", act_m[base+i], (i + 1) % 2);
      if (i > 0) check("rr_spacing", act_c[base+i] - act_c[base+i-1], 3);
    end
    drain();

    // m0 arrives while m1 is in ACCESS: four stall cycles, then m0's ack.
    new_req(1);
    wait_access_of(1);
    new_req(0);
    stall_cnt = 0;
    base = act_m.size();
    wait_acks(2, 20);
    check("stall_cycles", stall_cnt, 4);
    check("stall_owner", act_m[base+1], 0);
    drain();

    // Reset during an m1 write's ACCESS: no ack, then m1 is re-granted.
    set_req(1, 1'b1, 32'h20, 32'hCAFEF00D);
    wait_access_of(1);
    base = act_m.size();
    step(1'b0);
    check("rst_no_ack", act_m.size(), base);
    wait_acks(1, 10);
    check("rst_regrant", act_m[base], 1);
    drain();
    set_req(0, 1'b0, 32'h20, 32'h0);
    wait_acks(1, 10);
    check("rst_rd_data", act_d[act_d.size()-1], 32'hCAFEF00D);
    drain();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      for (int m = 0; m < 2; m++)
        if (!mst[m].active && $urandom_range(0, 2) == 0) new_req(m);
      step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end
    drain();

    // Fixed priority: with both masters requesting, m1 is never served.
    fp0 = 0;
    fp1 = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus_fp.m0_req = 1'b1; bus_fp.m0_addr = 32'h4;
        bus_fp.m1_req = 1'b1; bus_fp.m1_addr = 32'h8; bus_fp.m1_we = 1'b1;
      end
      #1;
      if (bus_fp.m0_ack === 1'b1) fp0++;
      if (bus_fp.m1_ack === 1'b1) fp1++;
    end
    check("fp_m1_acks", fp1, 0);
    check("fp_m0_acks", fp0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
